// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor and the update bus it consumes.
// Field widths match the execute-stage branch unit that packs to_pr_ibus.
package branch_predictor_pkg;

    localparam int ScountAddrWidth  = 10;
    localparam int ScountStateWidth = 2;
    localparam int BtbAddrWidth     = 6;
    localparam int BiatWidth        = 32;
    localparam int BtbTagWidth      = 29 - BtbAddrWidth;
    localparam int PtoWbusWidth     = 1 + ScountAddrWidth + ScountStateWidth + 2
                                    + BtbAddrWidth + BtbTagWidth + BiatWidth;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_table_ram.sv
// Generic table RAM: one synchronous read port and one synchronous write port.
// A read and write of the same address in one cycle returns the old contents.
module bp_table_ram #(
    parameter int DW = 2,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];
    logic [DW-1:0] rdata_r;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port; the output register holds whenever no read is issued
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor: 2-bit PHT plus direct-mapped BTB, one lookup per cycle, one-cycle latency.
// Tables are swept to a known state after reset before lookups are honoured.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int                            PHT_IDX_W = ScountAddrWidth,
    parameter int                            BTB_IDX_W = BtbAddrWidth,
    parameter logic [ScountStateWidth-1:0]   PHT_INIT  = 2'b01
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    input  logic [31:0]             req_pc_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic [PHT_IDX_W+ScountStateWidth+BiatWidth+31:0] to_pr_ibus,
    output logic                    resp_valid_o,
    output logic [31:0]             resp_pc_o,
    output logic                    pre_taken_o,
    output logic                    btb_hit_o,
    output logic [ScountStateWidth-1:0] pht_state_o,
    output logic [31:0]             pre_next_pc_o,
    output logic                    init_done_o
);

    localparam int TAG_W        = 29 - BTB_IDX_W;
    localparam int BTB_DW       = 1 + TAG_W + BiatWidth;
    localparam int BTB_TAG_LSB  = BiatWidth;
    localparam int BTB_ADDR_LSB = BTB_TAG_LSB + TAG_W;
    localparam int BTB_VLD_BIT  = BTB_ADDR_LSB + BTB_IDX_W;
    localparam int BTB_WE_BIT   = BTB_VLD_BIT + 1;
    localparam int PHT_DATA_LSB = BTB_WE_BIT + 1;
    localparam int PHT_ADDR_LSB = PHT_DATA_LSB + ScountStateWidth;
    localparam int PHT_WE_BIT   = PHT_ADDR_LSB + PHT_IDX_W;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } bp_state_e;

    bp_state_e                   state_r;
    logic [PHT_IDX_W-1:0]        cnt_r;
    logic                        init_done_r;
    logic                        resp_valid_r;
    logic [31:0]                 resp_pc_r;

    logic                        accept_s;
    logic                        pht_we_s;
    logic [PHT_IDX_W-1:0]        pht_waddr_s;
    logic [ScountStateWidth-1:0] pht_wdata_s;
    logic [ScountStateWidth-1:0] pht_rd_s;
    logic                        btb_we_s;
    logic [BTB_IDX_W-1:0]        btb_waddr_s;
    logic [BTB_DW-1:0]           btb_wdata_s;
    logic [BTB_DW-1:0]           btb_rd_s;
    logic                        btb_hit_s;
    logic                        taken_s;

    // Control FSM: init sweep, then response bookkeeping with flush over stall over request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_INIT;
            cnt_r        <= {PHT_IDX_W{1'b0}};
            init_done_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_pc_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + {{(PHT_IDX_W-1){1'b0}}, 1'b1};
                    if (cnt_r == {PHT_IDX_W{1'b1}}) begin
                        state_r     <= ST_READY;
                        init_done_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (flush_i) begin
                        resp_valid_r <= 1'b0;
                    end else if (!stall_i) begin
                        resp_valid_r <= accept_s;
                        if (accept_s) begin
                            resp_pc_r <= req_pc_i;
                        end
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    // Table write arbitration: the sweep owns both write ports until READY
    always_comb begin
        accept_s    = 1'b0;
        pht_we_s    = 1'b0;
        pht_waddr_s = {PHT_IDX_W{1'b0}};
        pht_wdata_s = {ScountStateWidth{1'b0}};
        btb_we_s    = 1'b0;
        btb_waddr_s = {BTB_IDX_W{1'b0}};
        btb_wdata_s = {BTB_DW{1'b0}};
        if (rst) begin
            accept_s = 1'b0;
        end else if (state_r == ST_INIT) begin
            pht_we_s    = 1'b1;
            pht_waddr_s = cnt_r;
            pht_wdata_s = PHT_INIT;
            btb_we_s    = (cnt_r[PHT_IDX_W-1:BTB_IDX_W] == {(PHT_IDX_W-BTB_IDX_W){1'b0}});
            btb_waddr_s = cnt_r[BTB_IDX_W-1:0];
            btb_wdata_s = {BTB_DW{1'b0}};
        end else begin
            accept_s    = req_valid_i & ~stall_i & ~flush_i;
            pht_we_s    = to_pr_ibus[PHT_WE_BIT];
            pht_waddr_s = to_pr_ibus[PHT_ADDR_LSB +: PHT_IDX_W];
            pht_wdata_s = to_pr_ibus[PHT_DATA_LSB +: ScountStateWidth];
            btb_we_s    = to_pr_ibus[BTB_WE_BIT];
            btb_waddr_s = to_pr_ibus[BTB_ADDR_LSB +: BTB_IDX_W];
            btb_wdata_s = {to_pr_ibus[BTB_VLD_BIT],
                           to_pr_ibus[BTB_TAG_LSB +: TAG_W],
                           to_pr_ibus[BiatWidth-1:0]};
        end
    end

    bp_table_ram #(.DW(ScountStateWidth), .AW(PHT_IDX_W)) u_pht (
        .clk   (clk),
        .re    (accept_s),
        .raddr (req_pc_i[PHT_IDX_W+2:3]),
        .rdata (pht_rd_s),
        .we    (pht_we_s),
        .waddr (pht_waddr_s),
        .wdata (pht_wdata_s)
    );

    bp_table_ram #(.DW(BTB_DW), .AW(BTB_IDX_W)) u_btb (
        .clk   (clk),
        .re    (accept_s),
        .raddr (req_pc_i[BTB_IDX_W+2:3]),
        .rdata (btb_rd_s),
        .we    (btb_we_s),
        .waddr (btb_waddr_s),
        .wdata (btb_wdata_s)
    );

    // Prediction from the captured table words; fields read as zero while no response is held
    always_comb begin
        btb_hit_s = btb_rd_s[BTB_DW-1] &
                    (btb_rd_s[BTB_TAG_LSB +: TAG_W] == resp_pc_r[31:BTB_IDX_W+3]);
        taken_s   = btb_hit_s & pht_rd_s[ScountStateWidth-1];
        if (resp_valid_r) begin
            btb_hit_o     = btb_hit_s;
            pre_taken_o   = taken_s;
            pht_state_o   = pht_rd_s;
            pre_next_pc_o = taken_s ? btb_rd_s[BiatWidth-1:0] : pc_plus4(resp_pc_r);
        end else begin
            btb_hit_o     = 1'b0;
            pre_taken_o   = 1'b0;
            pht_state_o   = {ScountStateWidth{1'b0}};
            pre_next_pc_o = 32'h0000_0000;
        end
    end

    assign resp_valid_o = resp_valid_r;
    assign resp_pc_o    = resp_pc_r;
    assign init_done_o  = init_done_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: randomized and directed lookups/updates against a table model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [31:0] req_pc_i;
    logic        stall_i;
    logic        flush_i;
    logic [75:0] to_pr_ibus;
    logic        resp_valid_o;
    logic [31:0] resp_pc_o;
    logic        pre_taken_o;
    logic        btb_hit_o;
    logic [1:0]  pht_state_o;
    logic [31:0] pre_next_pc_o;
    logic        init_done_o;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_pc_i      (req_pc_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .to_pr_ibus    (to_pr_ibus),
        .resp_valid_o  (resp_valid_o),
        .resp_pc_o     (resp_pc_o),
        .pre_taken_o   (pre_taken_o),
        .btb_hit_o     (btb_hit_o),
        .pht_state_o   (pht_state_o),
        .pre_next_pc_o (pre_next_pc_o),
        .init_done_o   (init_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        hit;
        logic        taken;
        logic [1:0]  st;
        logic [31:0] npc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last;
    bit          have_last = 0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          model_ready = 0;

    logic [1:0]  m_pht [1024];
    bit          m_bv  [64];
    logic [22:0] m_bt  [64];
    logic [31:0] m_tgt [64];

    logic [31:0] pool [8] = '{32'h1C00_0010, 32'h1C00_0210, 32'h1C00_0018, 32'h0000_0000,
                              32'hFFFF_FFFC, 32'h2000_1000, 32'h1C00_1010, 32'h8000_0208};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_pht[i] = 2'b01;
        for (int i = 0; i < 64; i++) m_bv[i] = 1'b0;
    endtask

    function automatic exp_t predict(input logic [31:0] pc, input int c);
        exp_t e;
        int pi = int'((pc >> 3) % 1024);
        int bi = int'((pc >> 3) % 64);
        logic [22:0] tag = 23'(pc >> 9);
        e.cyc   = c;
        e.pc    = pc;
        e.hit   = m_bv[bi] && (m_bt[bi] == tag);
        e.st    = m_pht[pi];
        e.taken = e.hit && (m_pht[pi] >= 2'd2);
        e.npc   = e.taken ? m_tgt[bi] : pc + 32'd4;
        return e;
    endfunction

    task automatic step(input bit req, input logic [31:0] pc, input bit st, input bit fl,
                        input bit pwe, input logic [9:0] pa, input logic [1:0] pd,
                        input bit bwe, input bit bv, input logic [5:0] ba,
                        input logic [22:0] bt, input logic [31:0] bd);
        @(negedge clk);
        req_valid_i = req;
        req_pc_i    = pc;
        stall_i     = st;
        flush_i     = fl;
        to_pr_ibus  = {pwe, pa, pd, bwe, bv, ba, bt, bd};
        if (model_ready && req && !st && !fl) sb_q.push_back(predict(pc, cyc + 1));
        if (model_ready) begin
            if (pwe) m_pht[pa] = pd;
            if (bwe) begin
                m_bv[ba]  = bv;
                m_bt[ba]  = bt;
                m_tgt[ba] = bd;
            end
        end
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 6'd0, 23'd0, 32'd0);
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 6'd0, 23'd0, 32'd0);
    endtask

    task automatic check_reset();
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_done", 32'(init_done_o), 32'd0);
        chk("rst_taken", 32'(pre_taken_o), 32'd0);
        chk("rst_hit", 32'(btb_hit_o), 32'd0);
        chk("rst_state", 32'(pht_state_o), 32'd0);
        chk("rst_pc", resp_pc_o, 32'd0);
        chk("rst_npc", pre_next_pc_o, 32'd0);
    endtask

    // Releases reset and counts edges to init_done while throwing requests and updates at the sweep
    task automatic wait_init();
        int n = 0;
        bit done = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            rst         = 1'b0;
            req_valid_i = 1'($urandom_range(1, 0));
            req_pc_i    = 32'h1C00_0010;
            stall_i     = 1'b0;
            flush_i     = 1'b0;
            to_pr_ibus  = ($urandom_range(3, 0) == 0) ?
                          {1'b1, 10'd2, 2'b11, 1'b1, 1'b1, 6'd2, 23'h0E0000, 32'h1C00_0400} : 76'd0;
            @(posedge clk);
            #1;
            n++;
            if (init_done_o) done = 1;
        end
        chk("init_cycles", 32'(n), 32'd1024);
        model_ready = 1;
    endtask

    // Monitor: pops on each fresh response, checks frozen outputs on stalled cycles
    initial begin
        exp_t e;
        bit st_q, fl_q, rs_q;
        forever begin
            @(posedge clk);
            cyc++;
            st_q = stall_i;
            fl_q = flush_i;
            rs_q = rst;
            #1;
            if (resp_valid_o) begin
                if (st_q && !fl_q && !rs_q && have_last) begin
                    chk("hold_pc", resp_pc_o, last.pc);
                    chk("hold_hit", 32'(btb_hit_o), 32'(last.hit));
                    chk("hold_taken", 32'(pre_taken_o), 32'(last.taken));
                    chk("hold_state", 32'(pht_state_o), 32'(last.st));
                    chk("hold_npc", pre_next_pc_o, last.npc);
                end else if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid_o), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    last = e;
                    have_last = 1;
                    chk("latency", 32'(cyc), 32'(e.cyc));
                    chk("resp_pc", resp_pc_o, e.pc);
                    chk("btb_hit", 32'(btb_hit_o), 32'(e.hit));
                    chk("pre_taken", 32'(pre_taken_o), 32'(e.taken));
                    chk("pht_state", 32'(pht_state_o), 32'(e.st));
                    chk("next_pc", pre_next_pc_o, e.npc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0;
        req_pc_i = 32'd0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        to_pr_ibus = 76'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset();
        wait_init();

        // cold lookup, then train the entry and look it up and its alias
        look(32'h1C00_0010);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 10'd2, 2'b11, 1'b1, 1'b1, 6'd2, 23'h0E0000, 32'h1C00_0400);
        look(32'h1C00_0010);
        look(32'h1C00_0210);

        // same-cycle update and lookup returns old contents, then new ones
        step(1'b1, 32'h1C00_0010, 1'b0, 1'b0, 1'b1, 10'd2, 2'b00, 1'b1, 1'b1, 6'd2, 23'h0E0000, 32'h1C00_0800);
        look(32'h1C00_0010);

        // stall for 3 cycles, then flush with request, then flush over stall
        look(32'h1C00_0018);
        repeat (3) step(1'b1, 32'h1C00_0010, 1'b1, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 6'd0, 23'd0, 32'd0);
        step(1'b1, 32'h1C00_0010, 1'b0, 1'b1, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 6'd0, 23'd0, 32'd0);
        step(1'b1, 32'h1C00_0010, 1'b1, 1'b1, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 6'd0, 23'd0, 32'd0);
        idle();

        // pc+4 wraps around
        look(32'hFFFF_FFFC);
        idle();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] p;
            logic [31:0] q;
            p = pool[$urandom_range(7, 0)];
            q = pool[$urandom_range(7, 0)];
            step($urandom_range(3, 0) != 0, p, $urandom_range(7, 0) == 0, $urandom_range(15, 0) == 0,
                 $urandom_range(2, 0) == 0, q[12:3], 2'($urandom),
                 $urandom_range(2, 0) == 0, $urandom_range(3, 0) != 0, q[8:3],
                 ($urandom_range(3, 0) == 0) ? 23'($urandom) : q[31:9],
                 32'($urandom) & 32'hFFFF_FFFC);
        end
        repeat (3) idle();

        // reset in READY with a request in the same cycle: tables re-swept
        @(negedge clk);
        model_ready = 0;
        rst = 1'b1;
        req_valid_i = 1'b1;
        req_pc_i = 32'h1C00_0010;
        to_pr_ibus = 76'd0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        model_reset();
        check_reset();
        wait_init();
        look(32'h1C00_0010);
        look(32'h1C00_1010);
        repeat (3) idle();

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
